or1200_sstk_spill: RTL and testbench
====================================

Name: or1200_sstk_spill

Overview:
Return-address shadow stack with a bounded on-chip buffer that spills to memory and fills back from it.
- Receives push requests (call link address) and pop requests (actual return target) from the OR1200 ex stage over valid/ready handshakes.
- Checks each popped entry against the actual return target and flags mismatches.
- When the on-chip buffer overflows, writes the oldest entries to a reserved memory region through a Wishbone master. When it underflows, reads entries back.

Parameters:
- DEPTH, 16: on-chip entries; power of 2, minimum 2.
- MEM_DEPTH, 1024: maximum number of spilled entries held in memory.
- SPILL_BASE, 32'h0000_F000: byte base address of the spill region; word-aligned.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- push_valid  in  1  call (l.jal/l.jalr) retiring
- push_addr  in  32  link address to save
- push_ready  out  1  push accepted this cycle when high
- pop_valid  in  1  l.jr r9 retiring
- pop_addr  in  32  actual jump target (operand_b)
- pop_ready  out  1  pop accepted this cycle when high
- chk_valid  out  1  one-cycle pulse; compare result valid
- chk_match  out  1  expected == pop_addr
- chk_expected  out  32  shadow value used for the compare
- violation  out  1  mismatch or underflow indication
- ovf  out  1  sticky: memory region full, oldest entry dropped
- bus_err  out  1  sticky: wb_err_i seen
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone master controls
- wb_adr_o  out  32  address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  always 4'hF during a cycle
- wb_dat_i  in  32  read data
- wb_ack_i, wb_err_i  in  1  termination

Behaviour:
- Reset values:
  - cnt=0, mcnt=0, state IDLE.
  - All outputs 0, except push_ready=1 and pop_ready=1.
  - Buffer contents undefined.
- Storage: circular buffer with bot pointer and cnt. The top entry is (bot+cnt-1) mod DEPTH. Pointers wrap modulo DEPTH.
- FSM states: IDLE, SPILL, FILL.
  - push_ready = IDLE & !pop_valid.
  - pop_ready = IDLE.
  - Pop has priority over push when both are valid in the same cycle.
- Push in IDLE:
  - cnt<DEPTH: write the entry at top+1 and increment cnt.
  - cnt==DEPTH: push_ready is deasserted that cycle and the FSM goes to SPILL. The push is accepted on the first IDLE cycle after the spill completes.
- SPILL:
  - Drives cyc=stb=we=1, adr=SPILL_BASE+4*mcnt, dat=buf[bot].
  - On ack: mcnt++, bot++, cnt--, return to IDLE.
  - If mcnt==MEM_DEPTH on entry: no bus cycle; drop buf[bot] (bot++, cnt--), set ovf, return to IDLE next cycle.
  - On wb_err_i: drop the entry as in the ovf case and set bus_err.
- Pop in IDLE:
  - cnt>0: expected=buf[top], cnt--. The next cycle gives chk_valid=1, chk_expected=expected, chk_match=(expected==pop_addr). pop_addr is latched at the handshake.
  - cnt==0 and mcnt>0: go to FILL.
  - cnt==0 and mcnt==0 (underflow): next cycle gives chk_valid=1, chk_match=0, chk_expected=0.
- FILL:
  - Drives cyc=stb=1, we=0, adr=SPILL_BASE+4*(mcnt-1).
  - On ack: mcnt--. The cycle after ack gives a chk pulse using wb_dat_i, latched at ack. The value is consumed and not stored in the buffer.
  - On wb_err_i: mcnt--, set bus_err, chk_match=0.
- violation = chk_valid & !chk_match.
- Wishbone: cyc/stb are held until ack or err and drop in the cycle after termination. Single-beat transfers only.
- Reset mid-transaction: cyc/stb drop the next cycle, all state clears, the bus cycle is abandoned.

Optional Feature:
Macro OR1200_SSTK_VIOL_STICKY_EN.
- Defined: violation is a sticky flag. It is set by any failing chk pulse and cleared only by rst.
- Undefined: violation is a one-cycle pulse aligned with chk_valid.

Decomposition:
- Shared package or1200_sstk_pkg holds:
  - state encoding (IDLE, SPILL, FILL)
  - word stride constant 4
  - default SPILL_BASE
  - DEPTH-derived pointer width function
- One sub-module, or1200_sstk_buf: DEPTH x 32 register file with one write port and one combinational read port.

Test Plan:
- 3 pushes (0x100, 0x200, 0x300), then 3 pops with matching pop_addr → chk_match=1 three times, expected values 0x300, 0x200, 0x100.
- DEPTH=4, 5 pushes 0x10..0x50 → one write of 0x10 to 0xF000, push_ready low for ≥2 cycles, mcnt=1.
- Continue that case with 5 pops → first four checks come from the buffer. The fifth issues a read at 0xF000; with the ack returning 0x10 and pop_addr=0x10, chk_match=1.
- Pop with a mismatched target (expected 0x300, pop_addr 0x304) → chk_valid=1, chk_match=0, violation asserted.
- Pop on an empty stack → chk_match=0, violation asserted, no bus cycle.
- MEM_DEPTH=1, DEPTH=2, 4 pushes → first spill on the bus, second spill drops the entry and sets ovf; wb_err_i during a fill sets bus_err and chk_match=0.

Source files
------------

// File: rtl/or1200_sstk_pkg.sv
// Shared definitions for the OR1200 return-address shadow stack.
// Contains the FSM encoding, the spill word stride, the default spill base and the pointer-width helper.
package or1200_sstk_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPILL = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;

    localparam logic [31:0] WORD_STRIDE     = 32'd4;
    localparam logic [31:0] SSTK_SPILL_BASE = 32'h0000_F000;

    function automatic int sstk_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/or1200_sstk_buf.sv
// On-chip shadow-stack storage: DEPTH x 32 register file.
// One synchronous write port and one combinational read port; the contents are not reset.
module or1200_sstk_buf
    import or1200_sstk_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PW    = sstk_ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [PW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/or1200_sstk_spill.sv
// Return-address shadow stack with a circular on-chip buffer that spills to and fills from memory over Wishbone.
// Optional build macro OR1200_SSTK_VIOL_STICKY_EN makes violation sticky until rst; otherwise it is a pulse.
//   state | meaning
//   IDLE  | accept push/pop, compare pops against the buffer
//   SPILL | write oldest entry to memory (or drop it when memory is full)
//   FILL  | read newest spilled entry back and compare it
module or1200_sstk_spill
    import or1200_sstk_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter int          MEM_DEPTH  = 1024,
    parameter logic [31:0] SPILL_BASE = SSTK_SPILL_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_valid,
    input  logic [31:0] push_addr,
    output logic        push_ready,
    input  logic        pop_valid,
    input  logic [31:0] pop_addr,
    output logic        pop_ready,
    output logic        chk_valid,
    output logic        chk_match,
    output logic [31:0] chk_expected,
    output logic        violation,
    output logic        ovf,
    output logic        bus_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int PW  = sstk_ptr_w(DEPTH);
    localparam int MCW = $clog2(MEM_DEPTH + 1);

    localparam logic [PW:0]    CNT_FULL = DEPTH[PW:0];
    localparam logic [PW:0]    CNT_ONE  = 1;
    localparam logic [PW-1:0]  PTR_ONE  = 1;
    localparam logic [MCW-1:0] MC_FULL  = MEM_DEPTH[MCW-1:0];
    localparam logic [MCW-1:0] MC_ONE   = 1;

    logic [1:0]     state;
    logic [PW:0]    cnt;
    logic [PW-1:0]  bot;
    logic [MCW-1:0] mcnt;
    logic [31:0]    pop_lat;

    logic [PW-1:0]  top_ptr, wr_ptr, rd_ptr;
    logic [31:0]    rd_data, mcnt_w;
    logic           full, empty, mem_full, spill_bus, fill_bus, push_fire;

    assign full      = (cnt == CNT_FULL);
    assign empty     = (cnt == '0);
    assign mem_full  = (mcnt == MC_FULL);
    assign top_ptr   = bot + cnt[PW-1:0] - PTR_ONE;
    assign wr_ptr    = bot + cnt[PW-1:0];
    assign rd_ptr    = (state == ST_SPILL) ? bot : top_ptr;

    assign push_ready = (state == ST_IDLE) && !pop_valid && !(push_valid && full);
    assign pop_ready  = (state == ST_IDLE);
    assign push_fire  = push_valid && push_ready;

    // A spill with the memory region full never touches the bus.
    assign spill_bus = (state == ST_SPILL) && !mem_full;
    assign fill_bus  = (state == ST_FILL);
    assign mcnt_w    = 32'(mcnt);

    assign wb_cyc_o = spill_bus || fill_bus;
    assign wb_stb_o = spill_bus || fill_bus;
    assign wb_we_o  = spill_bus;
    assign wb_sel_o = (spill_bus || fill_bus) ? 4'hF : 4'h0;
    assign wb_dat_o = spill_bus ? rd_data : 32'h0;
    assign wb_adr_o = spill_bus ? SPILL_BASE + mcnt_w * WORD_STRIDE :
                      fill_bus  ? SPILL_BASE + (mcnt_w - 32'd1) * WORD_STRIDE : 32'h0;

    or1200_sstk_buf #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_buf (
        .clk   (clk),
        .we    (push_fire),
        .waddr (wr_ptr),
        .wdata (push_addr),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bot          <= '0;
            mcnt         <= '0;
            pop_lat      <= 32'h0;
            chk_valid    <= 1'b0;
            chk_match    <= 1'b0;
            chk_expected <= 32'h0;
            ovf          <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            chk_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop_valid) begin
                        if (!empty) begin
                            cnt          <= cnt - CNT_ONE;
                            chk_valid    <= 1'b1;
                            chk_expected <= rd_data;
                            chk_match    <= (rd_data == pop_addr);
                        end else if (mcnt != '0) begin
                            pop_lat <= pop_addr;
                            state   <= ST_FILL;
                        end else begin
                            chk_valid    <= 1'b1;
                            chk_match    <= 1'b0;
                            chk_expected <= 32'h0;
                        end
                    end else if (push_valid) begin
                        if (full) state <= ST_SPILL;
                        else      cnt   <= cnt + CNT_ONE;
                    end
                end
                ST_SPILL: begin
                    if (mem_full) begin
                        bot   <= bot + PTR_ONE;
                        cnt   <= cnt - CNT_ONE;
                        ovf   <= 1'b1;
                        state <= ST_IDLE;
                    end else if (wb_ack_i) begin
                        mcnt  <= mcnt + MC_ONE;
                        bot   <= bot + PTR_ONE;
                        cnt   <= cnt - CNT_ONE;
                        state <= ST_IDLE;
                    end else if (wb_err_i) begin
                        bot     <= bot + PTR_ONE;
                        cnt     <= cnt - CNT_ONE;
                        bus_err <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (wb_ack_i) begin
                        mcnt         <= mcnt - MC_ONE;
                        chk_valid    <= 1'b1;
                        chk_expected <= wb_dat_i;
                        chk_match    <= (wb_dat_i == pop_lat);
                        state        <= ST_IDLE;
                    end else if (wb_err_i) begin
                        mcnt         <= mcnt - MC_ONE;
                        bus_err      <= 1'b1;
                        chk_valid    <= 1'b1;
                        chk_match    <= 1'b0;
                        chk_expected <= 32'h0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef OR1200_SSTK_VIOL_STICKY_EN
    logic viol_q;

    always_ff @(posedge clk) begin
        if (rst)                        viol_q <= 1'b0;
        else if (chk_valid && !chk_match) viol_q <= 1'b1;
    end

    assign violation = viol_q || (chk_valid && !chk_match);
`else
    assign violation = chk_valid && !chk_match;
`endif

endmodule

// File: tb/tb_or1200_sstk_spill.sv
// Directed bench for or1200_sstk_spill: instance 0 is DEPTH=4/MEM_DEPTH=1024, instance 1 is DEPTH=2/MEM_DEPTH=1.
// A Wishbone slave model with one wait state stores spilled words and can be switched to answer with err.
module tb_or1200_sstk_spill;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        push_valid [2] = '{1'b0, 1'b0};
    logic [31:0] push_addr  [2] = '{32'h0, 32'h0};
    logic        push_ready [2];
    logic        pop_valid  [2] = '{1'b0, 1'b0};
    logic [31:0] pop_addr   [2] = '{32'h0, 32'h0};
    logic        pop_ready  [2];
    logic        chk_valid  [2];
    logic        chk_match  [2];
    logic [31:0] chk_expected [2];
    logic        violation  [2];
    logic        ovf        [2];
    logic        bus_err    [2];
    logic        wb_cyc [2], wb_stb [2], wb_we [2];
    logic [31:0] wb_adr [2], wb_dat_o [2];
    logic [3:0]  wb_sel [2];
    logic [31:0] wb_dat_i [2] = '{32'h0, 32'h0};
    logic        wb_ack [2]   = '{1'b0, 1'b0};
    logic        wb_err [2]   = '{1'b0, 1'b0};

    logic        err_mode   [2] = '{1'b0, 1'b0};
    int          wait_cnt   [2] = '{0, 0};
    int          nwr        [2] = '{0, 0};
    int          nrd        [2] = '{0, 0};
    int          cyc_cycles [2] = '{0, 0};
    logic [31:0] last_wadr  [2] = '{32'h0, 32'h0};
    logic [31:0] last_wdat  [2] = '{32'h0, 32'h0};
    logic [31:0] last_radr  [2] = '{32'h0, 32'h0};
    logic [3:0]  last_sel   [2] = '{4'h0, 4'h0};
    logic [31:0] smem [2][4];

    int n_tests = 0;
    int n_fail  = 0;

    or1200_sstk_spill #(.DEPTH(4), .MEM_DEPTH(1024), .SPILL_BASE(32'h0000_F000)) u_dut_a (
        .clk(clk), .rst(rst),
        .push_valid(push_valid[0]), .push_addr(push_addr[0]), .push_ready(push_ready[0]),
        .pop_valid(pop_valid[0]), .pop_addr(pop_addr[0]), .pop_ready(pop_ready[0]),
        .chk_valid(chk_valid[0]), .chk_match(chk_match[0]), .chk_expected(chk_expected[0]),
        .violation(violation[0]), .ovf(ovf[0]), .bus_err(bus_err[0]),
        .wb_cyc_o(wb_cyc[0]), .wb_stb_o(wb_stb[0]), .wb_we_o(wb_we[0]),
        .wb_adr_o(wb_adr[0]), .wb_dat_o(wb_dat_o[0]), .wb_sel_o(wb_sel[0]),
        .wb_dat_i(wb_dat_i[0]), .wb_ack_i(wb_ack[0]), .wb_err_i(wb_err[0])
    );

    or1200_sstk_spill #(.DEPTH(2), .MEM_DEPTH(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .push_valid(push_valid[1]), .push_addr(push_addr[1]), .push_ready(push_ready[1]),
        .pop_valid(pop_valid[1]), .pop_addr(pop_addr[1]), .pop_ready(pop_ready[1]),
        .chk_valid(chk_valid[1]), .chk_match(chk_match[1]), .chk_expected(chk_expected[1]),
        .violation(violation[1]), .ovf(ovf[1]), .bus_err(bus_err[1]),
        .wb_cyc_o(wb_cyc[1]), .wb_stb_o(wb_stb[1]), .wb_we_o(wb_we[1]),
        .wb_adr_o(wb_adr[1]), .wb_dat_o(wb_dat_o[1]), .wb_sel_o(wb_sel[1]),
        .wb_dat_i(wb_dat_i[1]), .wb_ack_i(wb_ack[1]), .wb_err_i(wb_err[1])
    );

    // Slave model: one wait state, then ack (or err), released the cycle after.
    always begin
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            if (wb_cyc[g]) cyc_cycles[g]++;
            if (wb_ack[g] || wb_err[g]) begin
                wb_ack[g]   = 1'b0;
                wb_err[g]   = 1'b0;
                wait_cnt[g] = 0;
            end else if (wb_cyc[g] && wb_stb[g]) begin
                if (wait_cnt[g] == 0) begin
                    wait_cnt[g] = 1;
                end else begin
                    wait_cnt[g] = 0;
                    if (err_mode[g]) begin
                        wb_err[g] = 1'b1;
                    end else begin
                        wb_ack[g] = 1'b1;
                        if (wb_we[g]) begin
                            smem[g][wb_adr[g][3:2]] = wb_dat_o[g];
                            nwr[g]++;
                            last_wadr[g] = wb_adr[g];
                            last_wdat[g] = wb_dat_o[g];
                            last_sel[g]  = wb_sel[g];
                        end else begin
                            wb_dat_i[g] = smem[g][wb_adr[g][3:2]];
                            nrd[g]++;
                            last_radr[g] = wb_adr[g];
                        end
                    end
                end
            end
        end
    end

    // Holds push_valid until accepted; stall = cycles push_ready was low.
    task automatic do_push(input int i, input logic [31:0] a, output int stall);
        stall = 0;
        push_valid[i] = 1'b1;
        push_addr[i]  = a;
        #1;
        while (push_ready[i] !== 1'b1 && stall < 40) begin
            @(posedge clk);
            #3;
            stall++;
        end
        @(posedge clk);
        #2;
        push_valid[i] = 1'b0;
        push_addr[i]  = 32'h0;
    endtask

    // Pops once, scrambles pop_addr after the handshake, waits for the chk pulse.
    task automatic do_pop(input int i, input logic [31:0] a, output int lat);
        int stall;
        stall = 0;
        pop_valid[i] = 1'b1;
        pop_addr[i]  = a;
        #1;
        while (pop_ready[i] !== 1'b1 && stall < 40) begin
            @(posedge clk);
            #3;
            stall++;
        end
        @(posedge clk);
        #2;
        pop_valid[i] = 1'b0;
        pop_addr[i]  = 32'hDEAD_BEEF;
        lat = 0;
        while (chk_valid[i] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #2;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (push_ready[i] !== 1'b1 || pop_ready[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready[%0d]: got push=%b pop=%b expected 1 1", i, push_ready[i], pop_ready[i]);
            end
            n_tests++;
            if ({chk_valid[i], chk_match[i], violation[i], ovf[i], bus_err[i], wb_cyc[i], wb_stb[i], wb_we[i]} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: got chk_v=%b m=%b viol=%b ovf=%b berr=%b cyc=%b stb=%b we=%b expected all 0",
                         i, chk_valid[i], chk_match[i], violation[i], ovf[i], bus_err[i], wb_cyc[i], wb_stb[i], wb_we[i]);
            end
            n_tests++;
            if (chk_expected[i] !== 32'h0 || wb_adr[i] !== 32'h0 || wb_sel[i] !== 4'h0 || wb_dat_o[i] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_buses[%0d]: got exp=%h adr=%h sel=%h dat=%h expected zeros",
                         i, chk_expected[i], wb_adr[i], wb_sel[i], wb_dat_o[i]);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] vals [3];
        int st, lat;
        vals = '{32'h100, 32'h200, 32'h300};
        for (int k = 0; k < 3; k++) begin
            do_push(0, vals[k], st);
            n_tests++;
            if (st !== 0) begin
                n_fail++;
                $display("FAIL basic_push_stall[%0d]: got %0d expected 0", k, st);
            end
        end
        for (int k = 2; k >= 0; k--) begin
            do_pop(0, vals[k], lat);
            n_tests++;
            if (lat !== 0 || chk_match[0] !== 1'b1 || chk_expected[0] !== vals[k] || violation[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_pop[%0d]: got lat=%0d match=%b exp=%h viol=%b expected lat=0 match=1 exp=%h viol=0",
                         k, lat, chk_match[0], chk_expected[0], violation[0], vals[k]);
            end
        end
    endtask

    task automatic test_mismatch();
        int st, lat;
        do_push(0, 32'h300, st);
        do_pop(0, 32'h304, lat);
        n_tests++;
        if (lat !== 0 || chk_valid[0] !== 1'b1 || chk_match[0] !== 1'b0 || chk_expected[0] !== 32'h300 || violation[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mismatch: got lat=%0d v=%b match=%b exp=%h viol=%b expected 0 1 0 00000300 1",
                     lat, chk_valid[0], chk_match[0], chk_expected[0], violation[0]);
        end
        @(posedge clk);
        #2;
        n_tests++;
`ifdef OR1200_SSTK_VIOL_STICKY_EN
        if (chk_valid[0] !== 1'b0 || violation[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mismatch_after: got v=%b viol=%b expected v=0 viol=1 (sticky)", chk_valid[0], violation[0]);
        end
`else
        if (chk_valid[0] !== 1'b0 || violation[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mismatch_after: got v=%b viol=%b expected 0 0", chk_valid[0], violation[0]);
        end
`endif
    endtask

    task automatic test_empty();
        int lat, c0;
        c0 = cyc_cycles[0];
        do_pop(0, 32'h55, lat);
        n_tests++;
        if (lat !== 0 || chk_match[0] !== 1'b0 || chk_expected[0] !== 32'h0 || violation[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_pop: got lat=%0d match=%b exp=%h viol=%b expected 0 0 00000000 1",
                     lat, chk_match[0], chk_expected[0], violation[0]);
        end
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (cyc_cycles[0] !== c0 || wb_cyc[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_no_bus: got cyc_cycles=%0d cyc=%b expected %0d 0", cyc_cycles[0], wb_cyc[0], c0);
        end
    endtask

    task automatic test_priority();
        int st, lat;
        do_push(0, 32'hA0, st);
        push_valid[0] = 1'b1;
        push_addr[0]  = 32'hB0;
        pop_valid[0]  = 1'b1;
        pop_addr[0]   = 32'hA0;
        #1;
        n_tests++;
        if (push_ready[0] !== 1'b0 || pop_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_ready: got push=%b pop=%b expected 0 1", push_ready[0], pop_ready[0]);
        end
        @(posedge clk);
        #2;
        push_valid[0] = 1'b0;
        pop_valid[0]  = 1'b0;
        n_tests++;
        if (chk_valid[0] !== 1'b1 || chk_match[0] !== 1'b1 || chk_expected[0] !== 32'hA0) begin
            n_fail++;
            $display("FAIL prio_pop: got v=%b match=%b exp=%h expected 1 1 000000a0", chk_valid[0], chk_match[0], chk_expected[0]);
        end
        do_pop(0, 32'hB0, lat);
        n_tests++;
        if (lat !== 0 || chk_match[0] !== 1'b0 || chk_expected[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL prio_push_dropped: got lat=%0d match=%b exp=%h expected 0 0 00000000", lat, chk_match[0], chk_expected[0]);
        end
    endtask

    task automatic test_spill_fill();
        logic [31:0] vals [5];
        int st, lat, c0;
        vals = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
        for (int k = 0; k < 4; k++) do_push(0, vals[k], st);
        do_push(0, vals[4], st);
        n_tests++;
        if (st < 2 || st >= 40) begin
            n_fail++;
            $display("FAIL spill_stall: got %0d cycles push_ready low expected 2..39", st);
        end
        n_tests++;
        if (nwr[0] !== 1 || last_wadr[0] !== 32'hF000 || last_wdat[0] !== 32'h10 || last_sel[0] !== 4'hF) begin
            n_fail++;
            $display("FAIL spill_write: got n=%0d adr=%h dat=%h sel=%h expected 1 0000f000 00000010 f",
                     nwr[0], last_wadr[0], last_wdat[0], last_sel[0]);
        end
        n_tests++;
        if (wb_cyc[0] !== 1'b0 || wb_stb[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL spill_release: got cyc=%b stb=%b expected 0 0", wb_cyc[0], wb_stb[0]);
        end
        for (int k = 4; k >= 1; k--) begin
            do_pop(0, vals[k], lat);
            n_tests++;
            if (lat !== 0 || chk_match[0] !== 1'b1 || chk_expected[0] !== vals[k]) begin
                n_fail++;
                $display("FAIL spill_pop[%0d]: got lat=%0d match=%b exp=%h expected 0 1 %h", k, lat, chk_match[0], chk_expected[0], vals[k]);
            end
        end
        do_pop(0, 32'h10, lat);
        n_tests++;
        if (lat == 0 || lat >= 40 || chk_match[0] !== 1'b1 || chk_expected[0] !== 32'h10 || violation[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_pop: got lat=%0d match=%b exp=%h viol=%b expected lat 1..39 1 00000010 0",
                     lat, chk_match[0], chk_expected[0], violation[0]);
        end
        n_tests++;
        if (nrd[0] !== 1 || last_radr[0] !== 32'hF000) begin
            n_fail++;
            $display("FAIL fill_read: got n=%0d adr=%h expected 1 0000f000", nrd[0], last_radr[0]);
        end
        c0 = cyc_cycles[0];
        do_pop(0, 32'h10, lat);
        n_tests++;
        if (lat !== 0 || chk_match[0] !== 1'b0 || cyc_cycles[0] !== c0) begin
            n_fail++;
            $display("FAIL fill_drained: got lat=%0d match=%b cyc_cycles=%0d expected 0 0 %0d", lat, chk_match[0], cyc_cycles[0], c0);
        end
    endtask

    task automatic test_ovf_err();
        int st, lat, c1;
        do_push(1, 32'h1, st);
        do_push(1, 32'h2, st);
        do_push(1, 32'h3, st);
        n_tests++;
        if (st < 2 || st >= 40 || nwr[1] !== 1 || last_wadr[1] !== 32'hF000 || last_wdat[1] !== 32'h1) begin
            n_fail++;
            $display("FAIL ovf_first_spill: got stall=%0d n=%0d adr=%h dat=%h expected >=2 1 0000f000 00000001",
                     st, nwr[1], last_wadr[1], last_wdat[1]);
        end
        n_tests++;
        if (ovf[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_early: got %b expected 0", ovf[1]);
        end
        c1 = cyc_cycles[1];
        do_push(1, 32'h4, st);
        n_tests++;
        if (st < 1 || st >= 40 || ovf[1] !== 1'b1 || nwr[1] !== 1 || cyc_cycles[1] !== c1 || bus_err[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drop: got stall=%0d ovf=%b n=%0d cyc_cycles=%0d berr=%b expected >=1 1 1 %0d 0",
                     st, ovf[1], nwr[1], cyc_cycles[1], bus_err[1], c1);
        end
        do_pop(1, 32'h4, lat);
        n_tests++;
        if (lat !== 0 || chk_match[1] !== 1'b1 || chk_expected[1] !== 32'h4) begin
            n_fail++;
            $display("FAIL ovf_pop4: got lat=%0d match=%b exp=%h expected 0 1 00000004", lat, chk_match[1], chk_expected[1]);
        end
        do_pop(1, 32'h3, lat);
        n_tests++;
        if (lat !== 0 || chk_match[1] !== 1'b1 || chk_expected[1] !== 32'h3) begin
            n_fail++;
            $display("FAIL ovf_pop3: got lat=%0d match=%b exp=%h expected 0 1 00000003", lat, chk_match[1], chk_expected[1]);
        end
        err_mode[1] = 1'b1;
        do_pop(1, 32'h1, lat);
        err_mode[1] = 1'b0;
        n_tests++;
        if (lat == 0 || lat >= 40 || chk_match[1] !== 1'b0 || violation[1] !== 1'b1 || bus_err[1] !== 1'b1 || nrd[1] !== 0) begin
            n_fail++;
            $display("FAIL fill_err: got lat=%0d match=%b viol=%b berr=%b nrd=%0d expected lat 1..39 0 1 1 0",
                     lat, chk_match[1], violation[1], bus_err[1], nrd[1]);
        end
        c1 = cyc_cycles[1];
        do_pop(1, 32'h1, lat);
        n_tests++;
        if (lat !== 0 || chk_match[1] !== 1'b0 || cyc_cycles[1] !== c1 || ovf[1] !== 1'b1 || bus_err[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL err_drained: got lat=%0d match=%b cyc_cycles=%0d ovf=%b berr=%b expected 0 0 %0d 1 1",
                     lat, chk_match[1], cyc_cycles[1], ovf[1], bus_err[1], c1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_empty();
        test_priority();
        test_spill_fill();
        test_ovf_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
